// File: rtl/wagu_add_stream.sv
// Purpose: streams weight-buffer read addresses for the ADD layer over a (row, piece, col) sweep.
// Latency: first read is presented the cycle after start; optional GAP_CYCLES idle cycles follow each read.
// Backpressure: a read is held (address and counters frozen) until i_wb_ready accepts it.
module wagu_add_stream #(
    parameter int          ADDR_W        = 13,
    parameter int          CNT_W         = 8,
    parameter int          GAP_CYCLES    = 1,
    parameter logic [3:0]  ADD_MODE_CODE = 4'd3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_calculate,
    input  logic [3:0]        mode,
    input  logic [ADDR_W-1:0] addr_start_w,
    input  logic [CNT_W-1:0]  out_x_length,
    input  logic [CNT_W-1:0]  in_piece,
    input  logic [CNT_W-1:0]  out_y_length,
    input  logic [ADDR_W-1:0] row_pitch,
    input  logic              abort,
    input  logic              i_wb_ready,
    output logic [ADDR_W-1:0] o_w_addr,
    output logic              o_rd_en,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

    localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  x_q, p_q, y_q;
    logic [CNT_W-1:0]  col_q, piece_q, row_q;
    logic [ADDR_W-1:0] pitch_q, row_base_q;
    logic [GW-1:0]     gap_q;

    logic start_ok, zero_len, col_end, piece_end, row_end, last, accept, gap_end;

    assign start_ok  = start_calculate && (mode == ADD_MODE_CODE);
    assign zero_len  = (out_x_length == '0) || (in_piece == '0) || (out_y_length == '0);
    assign col_end   = (col_q == x_q - CNT_W'(1));
    assign piece_end = (piece_q == p_q - CNT_W'(1));
    assign row_end   = (row_q == y_q - CNT_W'(1));
    assign last      = col_end && piece_end && row_end;
    assign accept    = (state_q == ISSUE) && i_wb_ready;
    assign gap_end   = (gap_q == '0);

    assign o_rd_en = (state_q == ISSUE);
    assign o_busy  = (state_q != IDLE);
    assign o_done  = (state_q == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = zero_len ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                if (i_wb_ready) begin
                    if (last) begin
                        state_d = DONE;
                    end else if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_end) begin
                    state_d = ISSUE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q        <= '0;
            p_q        <= '0;
            y_q        <= '0;
            pitch_q    <= '0;
            col_q      <= '0;
            piece_q    <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            gap_q      <= '0;
            o_w_addr   <= '0;
        end else if (abort) begin
            col_q   <= '0;
            piece_q <= '0;
            row_q   <= '0;
            gap_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        x_q        <= out_x_length;
                        p_q        <= in_piece;
                        y_q        <= out_y_length;
                        pitch_q    <= row_pitch;
                        col_q      <= '0;
                        piece_q    <= '0;
                        row_q      <= '0;
                        row_base_q <= addr_start_w;
                        o_w_addr   <= addr_start_w;
                    end
                end
                ISSUE: begin
                    if (accept && !last) begin
                        gap_q <= GW'(GAP_LAST);
                        // piece*x+col is contiguous within a row, so only a row wrap jumps by pitch
                        if (col_end) begin
                            col_q <= '0;
                            if (piece_end) begin
                                piece_q    <= '0;
                                row_q      <= row_q + CNT_W'(1);
                                row_base_q <= row_base_q + pitch_q;
                                o_w_addr   <= row_base_q + pitch_q;
                            end else begin
                                piece_q  <= piece_q + CNT_W'(1);
                                o_w_addr <= o_w_addr + ADDR_W'(1);
                            end
                        end else begin
                            col_q    <= col_q + CNT_W'(1);
                            o_w_addr <= o_w_addr + ADDR_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (!gap_end) begin
                        gap_q <= gap_q - GW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
